imem_loader: RTL and testbench

Host-side program loader for the tiny processor; replaces the fixed reset-time instruction image with a runtime download. It receives instruction bytes from the pins through a strobe handshake and writes them sequentially into instruction memory. While loading, it holds the core. When loading ends it issues a restart pulse so the PC and accumulator begin from address 0.

---
 rtl/imem_loader.sv | 107 ++++++++++
 tb/tb_imem_loader.sv | 291 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/imem_loader.sv
// Runtime instruction-memory loader: takes bytes from pins via a strobe handshake,
// writes them sequentially into imem, holds the core meanwhile and restarts it afterwards.
module imem_loader #(
  parameter int IMEM_SZ = 16,
  parameter int ADDR_W  = 4,
  parameter int DATA_W  = 8
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              load_en_i,
  input  logic              strobe_i,
  input  logic [DATA_W-1:0] data_i,
  output logic              wr_en_o,
  output logic [ADDR_W-1:0] wr_addr_o,
  output logic [DATA_W-1:0] wr_data_o,
  output logic              cpu_hold_o,
  output logic              cpu_restart_o,
  output logic              load_done_o,
  output logic [7:0]        checksum_o
);

  typedef enum logic [1:0] {IDLE, LOAD, DONE} state_t;

  state_t state, state_next;

  logic le_m, le_s;
  logic st_m, st_s, st_d;
  logic st_rise_q;
  logic [ADDR_W-1:0] addr_cnt;

  logic do_start, do_write, do_restart, last_word;

  // The extra registered rise stage sets the strobe-to-write latency at four clocks.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      le_m      <= 1'b0;
      le_s      <= 1'b0;
      st_m      <= 1'b0;
      st_s      <= 1'b0;
      st_d      <= 1'b0;
      st_rise_q <= 1'b0;
    end else begin
      le_m      <= load_en_i;
      le_s      <= le_m;
      st_m      <= strobe_i;
      st_s      <= st_m;
      st_d      <= st_s;
      st_rise_q <= (state == LOAD) && st_s && !st_d;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_next;
  end

  assign last_word = (addr_cnt == ADDR_W'(IMEM_SZ - 1));

  // Abort (load_en dropped) takes priority over a pending byte.
  always_comb begin
    state_next = state;
    case (state)
      IDLE: if (le_s) state_next = LOAD;
      LOAD: begin
        if (!le_s)                       state_next = IDLE;
        else if (st_rise_q && last_word) state_next = DONE;
      end
      DONE: if (!le_s) state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  always_comb begin
    cpu_hold_o = (state != IDLE);
    do_start   = (state == IDLE) && le_s;
    do_write   = (state == LOAD) && le_s && st_rise_q;
    do_restart = (state != IDLE) && !le_s;
  end

  // Registered datapath; load_done and checksum persist in IDLE until the next load starts.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_en_o       <= 1'b0;
      wr_addr_o     <= '0;
      wr_data_o     <= '0;
      cpu_restart_o <= 1'b0;
      load_done_o   <= 1'b0;
      checksum_o    <= 8'h00;
      addr_cnt      <= '0;
    end else begin
      wr_en_o       <= do_write;
      cpu_restart_o <= do_restart;
      if (do_start) begin
        addr_cnt    <= '0;
        checksum_o  <= 8'h00;
        load_done_o <= 1'b0;
      end else if (do_write) begin
        wr_addr_o  <= addr_cnt;
        wr_data_o  <= data_i;
        addr_cnt   <= addr_cnt + 1'b1;
        checksum_o <= checksum_o + 8'(data_i);
        if (last_word) load_done_o <= 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_imem_loader.sv
// Self-checking bench for imem_loader: a monitor records imem writes, and a behavioural
// model (expected memory image, next address, byte sum) predicts every observable result.
module tb_imem_loader;

  localparam int N = 16;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       load_en_i = 1'b0;
  logic       strobe_i = 1'b0;
  logic [7:0] data_i = 8'h00;
  logic       wr_en_o;
  logic [3:0] wr_addr_o;
  logic [7:0] wr_data_o;
  logic       cpu_hold_o;
  logic       cpu_restart_o;
  logic       load_done_o;
  logic [7:0] checksum_o;

  imem_loader #(.IMEM_SZ(N), .ADDR_W(4), .DATA_W(8)) dut (
    .clk(clk), .rst_n(rst_n), .load_en_i(load_en_i), .strobe_i(strobe_i), .data_i(data_i),
    .wr_en_o(wr_en_o), .wr_addr_o(wr_addr_o), .wr_data_o(wr_data_o),
    .cpu_hold_o(cpu_hold_o), .cpu_restart_o(cpu_restart_o),
    .load_done_o(load_done_o), .checksum_o(checksum_o)
  );

  always #5 clk = ~clk;

  int tests_run = 0;
  int tests_failed = 0;

  int write_cnt = 0;
  int restart_cnt = 0;
  int violations = 0;
  logic prev_we = 1'b0;
  logic [3:0] last_addr;
  logic [7:0] last_data;
  logic [7:0] act_mem [N];

  logic [7:0] exp_mem [N];
  int   exp_next = 0;
  int   exp_sum = 0;
  bit   m_loading = 0;
  bit   m_done = 0;

  // Monitor: builds the written image, counts restarts, flags back-to-back or unheld writes.
  always @(posedge clk) begin
    #1;
    if (wr_en_o) begin
      write_cnt++;
      last_addr = wr_addr_o;
      last_data = wr_data_o;
      act_mem[wr_addr_o] = wr_data_o;
      if (prev_we || !cpu_hold_o) violations++;
    end
    if (cpu_restart_o) restart_cnt++;
    prev_we = wr_en_o;
  end

  task automatic check(input string name, input int actual, input int expected);
    tests_run++;
    if (actual !== expected) begin
      tests_failed++;
      $display("[TB] FAIL %s: got %0h, expected %0h", name, actual, expected);
    end
  endtask

  task automatic wait_clk(input int n);
    repeat (n) @(posedge clk);
    #2;
  endtask

  task automatic send_byte(input logic [7:0] b, output int lat);
    int start;
    start = write_cnt;
    lat = 0;
    @(negedge clk) data_i = b;
    @(negedge clk) strobe_i = 1'b1;
    for (int c = 1; c <= 4; c++) begin
      @(posedge clk); #2;
      if (lat == 0 && write_cnt != start) lat = c;
    end
    @(negedge clk) strobe_i = 1'b0;
    for (int c = 5; c <= 8; c++) begin
      @(posedge clk); #2;
      if (lat == 0 && write_cnt != start) lat = c;
    end
  endtask

  task automatic load_byte(input logic [7:0] b);
    int start, lat;
    start = write_cnt;
    send_byte(b, lat);
    if (m_loading) begin
      exp_mem[exp_next] = b;
      exp_sum = (exp_sum + b) % 256;
      if (write_cnt - start !== 1) begin
        tests_run++; tests_failed++;
        $display("[TB] FAIL write_count: got %0d, expected 1", write_cnt - start);
      end else begin
        if (last_addr !== 4'(exp_next)) begin
          tests_run++; tests_failed++;
          $display("[TB] FAIL wr_addr: got %0d, expected %0d", last_addr, exp_next);
        end else tests_run++;
        if (last_data !== b) begin
          tests_run++; tests_failed++;
          $display("[TB] FAIL wr_data: got %0h, expected %0h", last_data, b);
        end else tests_run++;
        if (lat !== 4) begin
          tests_run++; tests_failed++;
          $display("[TB] FAIL latency: got %0d, expected 4", lat);
        end else tests_run++;
      end
      exp_next++;
      if (exp_next == N) begin
        m_loading = 0;
        m_done = 1;
      end
    end else begin
      if (write_cnt != start) begin
        tests_run++; tests_failed++;
        $display("[TB] FAIL ignored_strobe: got %0d writes, expected 0", write_cnt - start);
      end else tests_run++;
    end
    if (checksum_o !== 8'(exp_sum)) begin
      tests_run++; tests_failed++;
      $display("[TB] FAIL checksum: got %0h, expected %0h", checksum_o, exp_sum);
    end else tests_run++;
    if (load_done_o !== m_done) begin
      tests_run++; tests_failed++;
      $display("[TB] FAIL load_done: got %0b, expected %0b", load_done_o, m_done);
    end else tests_run++;
  endtask

  task automatic raise_load();
    @(negedge clk) load_en_i = 1'b1;
    wait_clk(4);
    m_loading = 1; m_done = 0; exp_next = 0; exp_sum = 0;
    if (cpu_hold_o !== 1'b1 || checksum_o !== 8'h00 || load_done_o !== 1'b0) begin
      tests_run++; tests_failed++;
      $display("[TB] FAIL load_entry: hold=%0b sum=%0h done=%0b, expected 1/00/0",
               cpu_hold_o, checksum_o, load_done_o);
    end else tests_run++;
  endtask

  task automatic drop_load();
    int start;
    start = restart_cnt;
    @(negedge clk) load_en_i = 1'b0;
    wait_clk(5);
    m_loading = 0;
    if (restart_cnt - start !== 1) begin
      tests_run++; tests_failed++;
      $display("[TB] FAIL restart_pulses: got %0d, expected 1", restart_cnt - start);
    end else tests_run++;
    if (cpu_hold_o !== 1'b0 || load_done_o !== m_done || checksum_o !== 8'(exp_sum)) begin
      tests_run++; tests_failed++;
      $display("[TB] FAIL after_drop: hold=%0b done=%0b sum=%0h, expected 0/%0b/%0h",
               cpu_hold_o, load_done_o, checksum_o, m_done, exp_sum);
    end else tests_run++;
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    #12;
    check("reset_outputs", {wr_en_o, wr_addr_o, wr_data_o, cpu_hold_o, cpu_restart_o,
                            load_done_o, checksum_o}, 0);
    @(negedge clk) rst_n = 1'b1;
    wait_clk(3);
    check("idle_hold", cpu_hold_o, 0);
  endtask

  task automatic test_full_load();
    logic [7:0] prog [N];
    prog = '{8'h44, 8'h0F, 8'h1E, 8'h22, 8'h1F, 8'h0E, 8'hF2, 8'h13,
             8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00};
    raise_load();
    for (int i = 0; i < N; i++) load_byte(prog[i]);
    check("full_done", load_done_o, 1);
    check("full_hold", cpu_hold_o, 1);
  endtask

  task automatic test_ignored_done();
    for (int i = 0; i < 2; i++) load_byte(8'($urandom));
    drop_load();
  endtask

  task automatic test_ignored_idle();
    for (int i = 0; i < 3; i++) load_byte(8'($urandom));
    check("idle_restarts_hold", cpu_hold_o, 0);
  endtask

  task automatic test_abort();
    raise_load();
    for (int i = 0; i < 5; i++) load_byte(8'($urandom));
    drop_load();
    check("abort_done_low", load_done_o, 0);
    raise_load();
    load_byte(8'($urandom));
    drop_load();
  endtask

  task automatic test_held_strobe();
    int start;
    @(negedge clk) strobe_i = 1'b1;
    start = write_cnt;
    raise_load();
    wait_clk(8);
    check("held_strobe_no_write", write_cnt - start, 0);
    @(negedge clk) strobe_i = 1'b0;
    wait_clk(2);
    load_byte(8'($urandom));
    drop_load();
  endtask

  task automatic test_async_reset();
    int rs;
    raise_load();
    for (int i = 0; i < 7; i++) load_byte(8'($urandom | 1));
    rs = restart_cnt;
    @(posedge clk);
    #3;
    rst_n = 1'b0;
    load_en_i = 1'b0;
    #1;
    check("async_reset_outputs", {wr_en_o, wr_addr_o, wr_data_o, cpu_hold_o, cpu_restart_o,
                                  load_done_o, checksum_o}, 0);
    m_loading = 0; m_done = 0; exp_sum = 0;
    @(negedge clk) rst_n = 1'b1;
    wait_clk(4);
    check("reset_no_restart", restart_cnt - rs, 0);
    check("reset_idle_hold", cpu_hold_o, 0);
    raise_load();
    load_byte(8'($urandom));
    drop_load();
  endtask

  task automatic test_checksum_wrap();
    raise_load();
    for (int i = 0; i < N; i++) load_byte(8'hFF);
    check("wrap_checksum", checksum_o, 8'hF0);
    drop_load();
  endtask

  task automatic test_abort_same_cycle();
    int ws, rs;
    raise_load();
    for (int i = 0; i < 3; i++) load_byte(8'($urandom));
    ws = write_cnt;
    rs = restart_cnt;
    @(negedge clk) data_i = 8'($urandom);
    @(negedge clk) begin load_en_i = 1'b0; strobe_i = 1'b1; end
    wait_clk(8);
    @(negedge clk) strobe_i = 1'b0;
    wait_clk(3);
    m_loading = 0;
    check("same_cycle_no_write", write_cnt - ws, 0);
    check("same_cycle_restart", restart_cnt - rs, 1);
    check("same_cycle_hold", cpu_hold_o, 0);
    check("same_cycle_checksum", checksum_o, exp_sum);
  endtask

  task automatic test_random_load();
    raise_load();
    for (int i = 0; i < N; i++) load_byte(8'($urandom));
    drop_load();
  endtask

  task automatic test_image();
    for (int i = 0; i < N; i++) check($sformatf("imem[%0d]", i), act_mem[i], exp_mem[i]);
    check("protocol_violations", violations, 0);
  endtask

  initial begin
    for (int i = 0; i < N; i++) begin act_mem[i] = 8'h00; exp_mem[i] = 8'h00; end
    test_reset();
    test_full_load();
    test_ignored_done();
    test_ignored_idle();
    test_abort();
    test_held_strobe();
    test_async_reset();
    test_checksum_wrap();
    test_abort_same_cycle();
    test_random_load();
    test_image();
    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
